// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared constants for the multi-cycle LC3 controller: opcode
//               values, FSM state encoding, memory-stage command codes and
//               the EXECUTE-state dispatch function.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    // Opcodes (ir[15:12])
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // Controller states
    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_MEM_IND   = 3'd3;
    localparam logic [2:0] ST_MEM_RD    = 3'd4;
    localparam logic [2:0] ST_MEM_WR    = 3'd5;
    localparam logic [2:0] ST_WRITEBACK = 3'd6;
    localparam logic [2:0] ST_UPDATE_PC = 3'd7;

    // Memory-stage command codes
    localparam logic [1:0] MEM_READ  = 2'd0;
    localparam logic [1:0] MEM_WRITE = 2'd1;
    localparam logic [1:0] MEM_IND   = 2'd2;
    localparam logic [1:0] MEM_IDLE  = 2'd3;

    // State following EXECUTE for a given opcode. Unlisted opcodes behave
    // as NOPs and go straight to the PC update.
    function automatic logic [2:0] exec_next(input logic [3:0] op);
        logic [2:0] nxt;
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: nxt = ST_WRITEBACK;
            OP_LD,  OP_LDR:                 nxt = ST_MEM_RD;
            OP_ST,  OP_STR:                 nxt = ST_MEM_WR;
            OP_LDI, OP_STI:                 nxt = ST_MEM_IND;
            default:                        nxt = ST_UPDATE_PC;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : lc3_wait_counter
// Description : Saturating wait-cycle counter for the controller watchdog.
//               expire pulses on the last permitted waiting cycle.
// Ports       : clock, reset      - clock / synchronous active-high reset
//               clear             - zero the counter (state change)
//               inc               - a waiting cycle with completion low
//               limit [CNT_W-1:0] - wait bound, 0 disables expiry
//               expire            - bound reached while still waiting
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_wait_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    // Clear wins over increment; the count sticks at all-ones instead of
    // wrapping so a stalled limit can never be re-armed by overflow.
    always_comb begin
        w_count_d = r_count_q;
        if (clear) begin
            w_count_d = '0;
        end else if (inc && (r_count_q != {CNT_W{1'b1}})) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign expire = inc && (limit != '0) && (r_count_q == (limit - 1'b1));

endmodule
`default_nettype wire

// File: rtl/lc3_controller.sv
`default_nettype none
// ============================================================================
// Module      : lc3_controller
// Description : Moore sequencer for the multi-cycle LC3 core. Steps each
//               instruction through FETCH, DECODE, EXECUTE, optional memory
//               states, WRITEBACK and UPDATE_PC, with an optional watchdog
//               on the fetch and memory waits.
// Ports       : clock, reset            - clock / synchronous active-high reset
//               complete_instr          - instruction read done
//               complete_data           - data access done
//               ir [15:0], psr [2:0]    - instruction register, {n,z,p}
//               enable_fetch/_decode/_execute/_writeback - stage strobes
//               enable_updatePC, br_taken - PC load strobe and target select
//               mem_state [1:0]         - 0 rd, 1 wr, 2 indirect, 3 idle
//               mem_timeout             - sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_controller #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] ir,
    input  logic [2:0]  psr,
    output logic        enable_fetch,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic [1:0]  mem_state,
    output logic        mem_timeout
);

    import lc3_pkg::*;

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(WAIT_LIMIT);

    logic [2:0] r_state_q, w_state_d;
    logic [3:0] r_op_q,    w_op_d;
    logic [2:0] r_nzp_q,   w_nzp_d;
    logic       r_mem_timeout_q, w_mem_timeout_d;

    logic w_in_mem;
    logic w_inc;
    logic w_done;
    logic w_clear;
    logic w_expire;
    logic w_unused_ir;

    // Only the opcode and condition field are consumed here.
    assign w_unused_ir = ^ir[8:0];

    assign w_in_mem = (r_state_q == ST_MEM_IND) || (r_state_q == ST_MEM_RD) ||
                      (r_state_q == ST_MEM_WR);

    // A waiting cycle: the relevant completion is low in a state that waits.
    assign w_inc  = ((r_state_q == ST_FETCH) && !complete_instr) ||
                    (w_in_mem && !complete_data);
    // The watchdog expiry stands in for a missing completion.
    assign w_done = !w_inc || w_expire;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_FETCH:     if (w_done) w_state_d = ST_DECODE;
            ST_DECODE:    w_state_d = ST_EXECUTE;
            ST_EXECUTE:   w_state_d = exec_next(r_op_q);
            ST_MEM_IND:   if (w_done) w_state_d = (r_op_q == OP_STI) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:    if (w_done) w_state_d = ST_WRITEBACK;
            ST_MEM_WR:    if (w_done) w_state_d = ST_UPDATE_PC;
            ST_WRITEBACK: w_state_d = ST_UPDATE_PC;
            ST_UPDATE_PC: w_state_d = ST_FETCH;
            default:      w_state_d = ST_FETCH;
        endcase
    end

    assign w_clear = (w_state_d != r_state_q);

    // Opcode and condition field are captured once; ir is don't-care later.
    assign w_op_d          = (r_state_q == ST_DECODE) ? ir[15:12] : r_op_q;
    assign w_nzp_d         = (r_state_q == ST_DECODE) ? ir[11:9]  : r_nzp_q;
    assign w_mem_timeout_d = r_mem_timeout_q || w_expire;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q       <= ST_FETCH;
            r_op_q          <= 4'd0;
            r_nzp_q         <= 3'd0;
            r_mem_timeout_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_op_q          <= w_op_d;
            r_nzp_q         <= w_nzp_d;
            r_mem_timeout_q <= w_mem_timeout_d;
        end
    end

    // With a zero limit the counter never expires, so it is always present.
    lc3_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_clear),
        .inc    (w_inc),
        .limit  (c_limit),
        .expire (w_expire)
    );

    // Strobes are forced quiet during the reset cycle so an aborted
    // instruction cannot emit a stray enable while the state is reloaded.
    assign enable_fetch     = !reset && (r_state_q == ST_FETCH);
    assign enable_decode    = !reset && (r_state_q == ST_DECODE);
    assign enable_execute   = !reset && (r_state_q == ST_EXECUTE);
    assign enable_writeback = !reset && (r_state_q == ST_WRITEBACK);
    assign enable_updatePC  = !reset && (r_state_q == ST_UPDATE_PC);

    // psr is live so a branch sees the flags from the writeback just done.
    assign br_taken = enable_updatePC &&
                      ((r_op_q == OP_JMP) || ((r_op_q == OP_BR) && |(r_nzp_q & psr)));

    always_comb begin
        mem_state = MEM_IDLE;
        if (!reset) begin
            case (r_state_q)
                ST_MEM_RD:  mem_state = MEM_READ;
                ST_MEM_WR:  mem_state = MEM_WRITE;
                ST_MEM_IND: mem_state = MEM_IND;
                default:    mem_state = MEM_IDLE;
            endcase
        end
    end

    assign mem_timeout = r_mem_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_controller
// Description : Self-checking bench for lc3_controller. Two instances share
//               stimulus: one with the watchdog off, one with WAIT_LIMIT=4.
//               Per-cycle expected output vectors are queued with the
//               stimulus and popped against both instances each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_controller;

    // Output vector layout: {fetch, updPC, br, dec, exe, wb, mem_state[1:0], timeout}
    localparam logic [8:0] E_IDLE = 9'b000000110;
    localparam logic [8:0] E_F    = 9'b100000110;
    localparam logic [8:0] E_D    = 9'b000100110;
    localparam logic [8:0] E_E    = 9'b000010110;
    localparam logic [8:0] E_WB   = 9'b000001110;
    localparam logic [8:0] E_UP   = 9'b010000110;
    localparam logic [8:0] E_UPT  = 9'b011000110;
    localparam logic [8:0] E_RD   = 9'b000000000;
    localparam logic [8:0] E_WR   = 9'b000000010;
    localparam logic [8:0] E_IND  = 9'b000000100;
    localparam logic [8:0] TO     = 9'b000000001;

    typedef struct {
        logic        rst;
        logic        ci;
        logic        cd;
        logic [15:0] ir;
        logic [2:0]  psr;
        logic [8:0]  ex;
        logic [8:0]  exw;
    } stim_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        complete_instr = 1'b0;
    logic        complete_data = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic [2:0]  psr = 3'b000;

    logic       d_ef, d_eu, d_br, d_ed, d_ee, d_ew, d_to;
    logic [1:0] d_ms;
    logic       w_ef, w_eu, w_br, w_ed, w_ee, w_ew, w_to;
    logic [1:0] w_ms;

    wire [8:0] outs   = {d_ef, d_eu, d_br, d_ed, d_ee, d_ew, d_ms, d_to};
    wire [8:0] outs_w = {w_ef, w_eu, w_br, w_ed, w_ee, w_ew, w_ms, w_to};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    stim_t      sq[$];
    logic [8:0] exp_q[$];
    logic [8:0] expw_q[$];

    always #5 clock = ~clock;

    lc3_controller u_dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .ir               (ir),
        .psr              (psr),
        .enable_fetch     (d_ef),
        .enable_updatePC  (d_eu),
        .br_taken         (d_br),
        .enable_decode    (d_ed),
        .enable_execute   (d_ee),
        .enable_writeback (d_ew),
        .mem_state        (d_ms),
        .mem_timeout      (d_to)
    );

    lc3_controller #(.WAIT_LIMIT(4), .CNT_W(8)) u_wd (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .ir               (ir),
        .psr              (psr),
        .enable_fetch     (w_ef),
        .enable_updatePC  (w_eu),
        .br_taken         (w_br),
        .enable_decode    (w_ed),
        .enable_execute   (w_ee),
        .enable_writeback (w_ew),
        .mem_state        (w_ms),
        .mem_timeout      (w_to)
    );

    task automatic add(input logic r, input logic ci, input logic cd, input logic [15:0] i,
                       input logic [2:0] p, input logic [8:0] e, input logic [8:0] ew);
        stim_t s;
        s.rst = r; s.ci = ci; s.cd = cd; s.ir = i; s.psr = p; s.ex = e; s.exw = ew;
        sq.push_back(s);
    endtask

    task automatic drive(input stim_t s);
        reset = s.rst; complete_instr = s.ci; complete_data = s.cd; ir = s.ir; psr = s.psr;
        exp_q.push_back(s.ex);
        expw_q.push_back(s.exw);
    endtask

    task automatic test_reset();
        logic [8:0] want, want_w;
        add(1, 0, 0, 16'h0000, 3'b000, E_IDLE, E_IDLE);
        add(0, 0, 1, 16'h0000, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h0000, 3'b000, E_F,    E_F);
        add(1, 1, 0, 16'h0000, 3'b000, E_IDLE, E_IDLE);
        add(0, 0, 0, 16'h0000, 3'b000, E_F,    E_F);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clock);
            want = exp_q.pop_front(); want_w = expw_q.pop_front();
            total++;
            if (outs !== want) begin
                bad++; $display("FAIL reset cyc=%0d got=%b want=%b", cyc, outs, want);
            end
            total++;
            if (outs_w !== want_w) begin
                bad++; $display("FAIL reset_wd cyc=%0d got=%b want=%b", cyc, outs_w, want_w);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_alu();
        logic [8:0] want, want_w;
        add(1, 0, 0, 16'h1042, 3'b000, E_IDLE, E_IDLE);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_F);
        add(0, 1, 0, 16'h1042, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h1042, 3'b000, E_D,    E_D);
        add(0, 0, 0, 16'h1042, 3'b111, E_E,    E_E);
        add(0, 0, 0, 16'h1042, 3'b111, E_WB,   E_WB);
        add(0, 0, 0, 16'h1042, 3'b111, E_UP,   E_UP);
        add(0, 0, 0, 16'h1042, 3'b111, E_F,    E_F);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clock);
            want = exp_q.pop_front(); want_w = expw_q.pop_front();
            total++;
            if (outs !== want) begin
                bad++; $display("FAIL alu cyc=%0d got=%b want=%b", cyc, outs, want);
            end
            total++;
            if (outs_w !== want_w) begin
                bad++; $display("FAIL alu_wd cyc=%0d got=%b want=%b", cyc, outs_w, want_w);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_ldi();
        logic [8:0] want, want_w;
        add(1, 0, 0, 16'hA200, 3'b000, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'hA200, 3'b000, E_F,    E_F);
        add(0, 0, 1, 16'hA200, 3'b000, E_D,    E_D);
        add(0, 0, 1, 16'hA200, 3'b000, E_E,    E_E);
        add(0, 0, 0, 16'hA200, 3'b000, E_IND,  E_IND);
        add(0, 0, 1, 16'hA200, 3'b000, E_IND,  E_IND);
        add(0, 0, 0, 16'hA200, 3'b000, E_RD,   E_RD);
        add(0, 0, 1, 16'hA200, 3'b000, E_RD,   E_RD);
        add(0, 0, 1, 16'hA200, 3'b000, E_WB,   E_WB);
        add(0, 0, 0, 16'hA200, 3'b000, E_UP,   E_UP);
        add(0, 0, 0, 16'hA200, 3'b000, E_F,    E_F);
        // LD with zero-wait memory: 6 cycles
        add(1, 0, 0, 16'h2000, 3'b000, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'h2000, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h2000, 3'b000, E_D,    E_D);
        add(0, 0, 0, 16'h2000, 3'b000, E_E,    E_E);
        add(0, 0, 1, 16'h2000, 3'b000, E_RD,   E_RD);
        add(0, 0, 0, 16'h2000, 3'b000, E_WB,   E_WB);
        add(0, 0, 0, 16'h2000, 3'b000, E_UP,   E_UP);
        add(0, 0, 0, 16'h2000, 3'b000, E_F,    E_F);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clock);
            want = exp_q.pop_front(); want_w = expw_q.pop_front();
            total++;
            if (outs !== want) begin
                bad++; $display("FAIL ldi cyc=%0d got=%b want=%b", cyc, outs, want);
            end
            total++;
            if (outs_w !== want_w) begin
                bad++; $display("FAIL ldi_wd cyc=%0d got=%b want=%b", cyc, outs_w, want_w);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_branch();
        logic [8:0] want, want_w;
        // BR z with psr switching to z only in UPDATE_PC: taken
        add(1, 0, 0, 16'h0405, 3'b000, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'h0405, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h0405, 3'b000, E_D,    E_D);
        add(0, 0, 0, 16'h0405, 3'b000, E_E,    E_E);
        add(0, 0, 0, 16'h0405, 3'b010, E_UPT,  E_UPT);
        add(0, 0, 0, 16'h0405, 3'b010, E_F,    E_F);
        // BR z with psr=n: not taken; ir changes after DECODE must not matter
        add(1, 0, 0, 16'h0405, 3'b100, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'h0405, 3'b100, E_F,    E_F);
        add(0, 0, 0, 16'h0405, 3'b100, E_D,    E_D);
        add(0, 0, 0, 16'hC1C0, 3'b100, E_E,    E_E);
        add(0, 0, 0, 16'hC1C0, 3'b100, E_UP,   E_UP);
        // JMP: always taken
        add(1, 0, 0, 16'hC1C0, 3'b000, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'hC1C0, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'hC1C0, 3'b000, E_D,    E_D);
        add(0, 0, 0, 16'hC1C0, 3'b000, E_E,    E_E);
        add(0, 0, 0, 16'hC1C0, 3'b000, E_UPT,  E_UPT);
        // BR with nzp=000: never taken
        add(1, 0, 0, 16'h0000, 3'b111, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'h0000, 3'b111, E_F,    E_F);
        add(0, 0, 0, 16'h0000, 3'b111, E_D,    E_D);
        add(0, 0, 0, 16'h0000, 3'b111, E_E,    E_E);
        add(0, 0, 0, 16'h0000, 3'b111, E_UP,   E_UP);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clock);
            want = exp_q.pop_front(); want_w = expw_q.pop_front();
            total++;
            if (outs !== want) begin
                bad++; $display("FAIL branch cyc=%0d got=%b want=%b", cyc, outs, want);
            end
            total++;
            if (outs_w !== want_w) begin
                bad++; $display("FAIL branch_wd cyc=%0d got=%b want=%b", cyc, outs_w, want_w);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_sti_abort();
        logic [8:0] want, want_w;
        // STI zero-wait: 6 cycles
        add(1, 0, 0, 16'hB200, 3'b000, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'hB200, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'hB200, 3'b000, E_D,    E_D);
        add(0, 0, 0, 16'hB200, 3'b000, E_E,    E_E);
        add(0, 0, 1, 16'hB200, 3'b000, E_IND,  E_IND);
        add(0, 0, 1, 16'hB200, 3'b000, E_WR,   E_WR);
        add(0, 0, 0, 16'hB200, 3'b000, E_UP,   E_UP);
        // STI aborted by reset while in MEM_WR
        add(1, 0, 0, 16'hB200, 3'b000, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'hB200, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'hB200, 3'b000, E_D,    E_D);
        add(0, 0, 0, 16'hB200, 3'b000, E_E,    E_E);
        add(0, 0, 1, 16'hB200, 3'b000, E_IND,  E_IND);
        add(0, 0, 0, 16'hB200, 3'b000, E_WR,   E_WR);
        add(1, 0, 0, 16'hB200, 3'b000, E_IDLE, E_IDLE);
        add(0, 0, 0, 16'hB200, 3'b000, E_F,    E_F);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clock);
            want = exp_q.pop_front(); want_w = expw_q.pop_front();
            total++;
            if (outs !== want) begin
                bad++; $display("FAIL sti cyc=%0d got=%b want=%b", cyc, outs, want);
            end
            total++;
            if (outs_w !== want_w) begin
                bad++; $display("FAIL sti_wd cyc=%0d got=%b want=%b", cyc, outs_w, want_w);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reserved();
        logic [8:0] want, want_w;
        add(1, 0, 0, 16'hD000, 3'b111, E_IDLE, E_IDLE);
        add(0, 1, 0, 16'hD000, 3'b111, E_F,    E_F);
        add(0, 0, 1, 16'hD000, 3'b111, E_D,    E_D);
        add(0, 0, 1, 16'hD000, 3'b111, E_E,    E_E);
        add(0, 0, 1, 16'hD000, 3'b111, E_UP,   E_UP);
        add(0, 0, 0, 16'hD000, 3'b111, E_F,    E_F);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clock);
            want = exp_q.pop_front(); want_w = expw_q.pop_front();
            total++;
            if (outs !== want) begin
                bad++; $display("FAIL reserved cyc=%0d got=%b want=%b", cyc, outs, want);
            end
            total++;
            if (outs_w !== want_w) begin
                bad++; $display("FAIL reserved_wd cyc=%0d got=%b want=%b", cyc, outs_w, want_w);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_watchdog();
        logic [8:0] want, want_w;
        // Fetch never completes: watchdog instance times out after 4 cycles
        add(1, 0, 0, 16'h1042, 3'b000, E_IDLE, E_IDLE);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_D  | TO);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_E  | TO);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_WB | TO);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_UP | TO);
        add(0, 0, 0, 16'h1042, 3'b000, E_F,    E_F  | TO);
        add(1, 0, 0, 16'h1042, 3'b000, E_IDLE, E_IDLE | TO);
        // LD whose data never completes: timeout in MEM_RD
        add(0, 1, 0, 16'h2000, 3'b000, E_F,    E_F);
        add(0, 0, 0, 16'h2000, 3'b000, E_D,    E_D);
        add(0, 0, 0, 16'h2000, 3'b000, E_E,    E_E);
        add(0, 0, 0, 16'h2000, 3'b000, E_RD,   E_RD);
        add(0, 0, 0, 16'h2000, 3'b000, E_RD,   E_RD);
        add(0, 0, 0, 16'h2000, 3'b000, E_RD,   E_RD);
        add(0, 0, 0, 16'h2000, 3'b000, E_RD,   E_RD);
        add(0, 0, 0, 16'h2000, 3'b000, E_RD,   E_WB | TO);
        add(0, 0, 0, 16'h2000, 3'b000, E_RD,   E_UP | TO);
        add(0, 0, 0, 16'h2000, 3'b000, E_RD,   E_F  | TO);
        add(1, 0, 0, 16'h2000, 3'b000, E_IDLE, E_IDLE | TO);
        add(0, 0, 0, 16'h2000, 3'b000, E_F,    E_F);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clock);
            want = exp_q.pop_front(); want_w = expw_q.pop_front();
            total++;
            if (outs !== want) begin
                bad++; $display("FAIL wdog_off cyc=%0d got=%b want=%b", cyc, outs, want);
            end
            total++;
            if (outs_w !== want_w) begin
                bad++; $display("FAIL wdog_on cyc=%0d got=%b want=%b", cyc, outs_w, want_w);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_alu();
        test_ldi();
        test_branch();
        test_sti_abort();
        test_reserved();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit reached: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
